// File: rtl/key_uart_tx.sv
// Keypad-to-UART bridge: hex key codes become ASCII bytes, buffered in a small
// FIFO and sent as 8N1 frames with a registered, glitch-free serial line.
module key_uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       IN_clk,
  input  logic       IN_rst,
  input  logic [3:0] IN_value,
  input  logic       IN_key,
  output logic       OUT_tx,
  output logic       OUT_busy,
  output logic       OUT_full,
  output logic       OUT_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          r_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_full;
  logic            r_overflow;
  logic            r_tx;
  logic            r_busy;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_idx;
  logic [TW-1:0]   r_timer;

  logic [7:0]      w_byte;
  logic [7:0]      w_head;
  logic            w_push;
  logic            w_pop;
  logic            w_bit_done;
  logic [CW-1:0]   w_count_next;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F' ('A' - 10 = 0x37)
  assign w_byte     = (IN_value < 4'd10) ? (8'h30 + {4'h0, IN_value})
                                         : (8'h37 + {4'h0, IN_value});
  assign w_push     = IN_key & ~r_full;
  assign w_pop      = (r_state == IDLE) && (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_bit_done = (r_timer == TW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge IN_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_byte;
    end
  end

  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_next;
      r_full     <= (w_count_next == CW'(FIFO_DEPTH));
      // A strobe against a full FIFO is dropped even if a pop frees a slot now
      r_overflow <= IN_key & r_full;
    end
  end

  // Line and busy are registered from the current state, so both lag it by one cycle
  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_timer   <= '0;
    end else begin
      r_busy <= (r_state != IDLE);
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_state   <= START;
          end
        end
        START: begin
          r_tx <= 1'b0;
          if (w_bit_done) begin
            r_timer <= '0;
            r_state <= DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DATA: begin
          r_tx <= r_shift[r_bit_idx];
          if (w_bit_done) begin
            r_timer <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        STOP: begin
          r_tx <= 1'b1;
          if (w_bit_done) begin
            r_timer <= '0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign OUT_tx       = r_tx;
  assign OUT_busy     = r_busy;
  assign OUT_full     = r_full;
  assign OUT_overflow = r_overflow;

endmodule
